hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core, sequencing the execute stage's forwarding muxes and the per-stage stall/flush controls. It resolves RAW hazards by forwarding or a one-cycle load-use bubble and squashes wrong-path instructions on a taken branch. It freezes the pipeline while data memory is not ready, and a bounded-wait FSM reports a fault on memory timeout.

---
 rtl/hazard_unit_if.sv | 52 +++++
 rtl/hazard_unit.sv | 184 ++++++++++++++++++
 tb/tb_hazard_unit.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-hazard signal bundle between the core datapath and hazard_unit.
// Latency: none (plain wires). Backpressure: none; stalls travel as o_stall_* level signals.
// Ports: master = datapath (drives i_*, reads o_*), slave = hazard_unit (reads i_*, drives o_*).
interface hazard_unit_if;
  logic [4:0]  i_rs1_D;
  logic [4:0]  i_rs2_D;
  logic [4:0]  i_rs1_E;
  logic [4:0]  i_rs2_E;
  logic [4:0]  i_register_file_wr_addr_E;
  logic        i_register_file_wr_en_E;
  logic        i_sel_result_E;
  logic [4:0]  i_register_file_wr_addr_M;
  logic        i_register_file_wr_en_M;
  logic [4:0]  i_register_file_wr_addr_W;
  logic        i_register_file_wr_en_W;
  logic        i_branch_taken_E;
  logic        i_data_memory_req_M;
  logic        i_data_memory_ready_M;

  logic [1:0]  o_fwdA_E;
  logic [1:0]  o_fwdB_E;
  logic        o_stall_F;
  logic        o_stall_D;
  logic        o_stall_E;
  logic        o_stall_M;
  logic        o_flush_D;
  logic        o_flush_E;
  logic        o_flush_W;
  logic        o_mem_fault;
  logic [31:0] o_stall_cycles;
  logic [31:0] o_flush_count;

  modport master (
    output i_rs1_D, i_rs2_D, i_rs1_E, i_rs2_E,
           i_register_file_wr_addr_E, i_register_file_wr_en_E, i_sel_result_E,
           i_register_file_wr_addr_M, i_register_file_wr_en_M,
           i_register_file_wr_addr_W, i_register_file_wr_en_W,
           i_branch_taken_E, i_data_memory_req_M, i_data_memory_ready_M,
    input  o_fwdA_E, o_fwdB_E, o_stall_F, o_stall_D, o_stall_E, o_stall_M,
           o_flush_D, o_flush_E, o_flush_W, o_mem_fault, o_stall_cycles, o_flush_count
  );

  modport slave (
    input  i_rs1_D, i_rs2_D, i_rs1_E, i_rs2_E,
           i_register_file_wr_addr_E, i_register_file_wr_en_E, i_sel_result_E,
           i_register_file_wr_addr_M, i_register_file_wr_en_M,
           i_register_file_wr_addr_W, i_register_file_wr_en_W,
           i_branch_taken_E, i_data_memory_req_M, i_data_memory_ready_M,
    output o_fwdA_E, o_fwdB_E, o_stall_F, o_stall_D, o_stall_E, o_stall_M,
           o_flush_D, o_flush_E, o_flush_W, o_mem_fault, o_stall_cycles, o_flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use bubble, branch squash, data-memory freeze with timeout fault.
// Latency: all hazard outputs are same-cycle combinational; o_mem_fault decodes the FAULT state.
// Backpressure: i_data_memory_ready_M low freezes F/D/E/M for at most MEM_TIMEOUT cycles, then FAULT.
// Ports: clk, clr (async active-high reset), hz (hazard_unit_if.slave). Parameter MEM_TIMEOUT (>=2).
// Build option: define HAZARD_PERF_CNT_EN to implement o_stall_cycles/o_flush_count; otherwise they read 0.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clr,
  hazard_unit_if.slave  hz
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;

  logic mstall;
  logic mem_fault;
  logic load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic branch_flush;

  // ---------------- memory-wait FSM: state register ----------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // ---------------- memory-wait FSM: next state ----------------
  // wait_cnt counts stalled cycles already spent on the current access; the
  // request cycle in RUN is the first, so FAULT follows exactly MEM_TIMEOUT stalls.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (hz.i_data_memory_req_M && !hz.i_data_memory_ready_M) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (hz.i_data_memory_ready_M) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt    = FAULT;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_ONE;
        end
      end
      FAULT: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------- memory-wait FSM: outputs ----------------
  // The ready cycle in MEM_WAIT releases the pipeline in the same cycle;
  // FAULT never stalls so the faulting access can drain.
  always_comb begin
    mstall    = 1'b0;
    mem_fault = 1'b0;
    unique case (state)
      RUN:      mstall    = hz.i_data_memory_req_M && !hz.i_data_memory_ready_M;
      MEM_WAIT: mstall    = !hz.i_data_memory_ready_M;
      FAULT:    mem_fault = 1'b1;
      default: begin
        mstall    = 1'b0;
        mem_fault = 1'b0;
      end
    endcase
  end

  // ---------------- forwarding: M stage has priority over W ----------------
  always_comb begin
    hz.o_fwdA_E = 2'b00;
    hz.o_fwdB_E = 2'b00;
    if (hz.i_register_file_wr_en_M && (hz.i_register_file_wr_addr_M != 5'd0) &&
        (hz.i_register_file_wr_addr_M == hz.i_rs1_E))
      hz.o_fwdA_E = 2'b10;
    else if (hz.i_register_file_wr_en_W && (hz.i_register_file_wr_addr_W != 5'd0) &&
             (hz.i_register_file_wr_addr_W == hz.i_rs1_E))
      hz.o_fwdA_E = 2'b01;

    if (hz.i_register_file_wr_en_M && (hz.i_register_file_wr_addr_M != 5'd0) &&
        (hz.i_register_file_wr_addr_M == hz.i_rs2_E))
      hz.o_fwdB_E = 2'b10;
    else if (hz.i_register_file_wr_en_W && (hz.i_register_file_wr_addr_W != 5'd0) &&
             (hz.i_register_file_wr_addr_W == hz.i_rs2_E))
      hz.o_fwdB_E = 2'b01;
  end

  // ---------------- stall / flush ----------------
  assign load_use = hz.i_sel_result_E && hz.i_register_file_wr_en_E &&
                    (hz.i_register_file_wr_addr_E != 5'd0) &&
                    ((hz.i_register_file_wr_addr_E == hz.i_rs1_D) ||
                     (hz.i_register_file_wr_addr_E == hz.i_rs2_D));

  // A memory freeze holds everything in place, so branch squash and the
  // load-use bubble wait until release; a taken branch kills the load-use
  // consumer anyway, so it wins over the bubble.
  always_comb begin
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_w      = 1'b0;
    branch_flush = 1'b0;
    if (mstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.i_branch_taken_E) begin
      flush_d      = 1'b1;
      flush_e      = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.o_stall_F   = stall_f;
  assign hz.o_stall_D   = stall_d;
  assign hz.o_stall_E   = stall_e;
  assign hz.o_stall_M   = stall_m;
  assign hz.o_flush_D   = flush_d;
  assign hz.o_flush_E   = flush_e;
  assign hz.o_flush_W   = flush_w;
  assign hz.o_mem_fault = mem_fault;

  // ---------------- performance counters (saturating) ----------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_f && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (branch_flush && (flush_count_q != 32'hFFFF_FFFF))
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign hz.o_stall_cycles = stall_cycles_q;
  assign hz.o_flush_count  = flush_count_q;
`else
  assign hz.o_stall_cycles = '0;
  assign hz.o_flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios plus randomized traffic checked against a behavioural model.
// Latency: outputs sampled 1 ns after inputs change at the falling edge.
// Backpressure: memory ready is driven by the bench to exercise freeze and timeout.
module tb_hazard_unit;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if hif ();

  hazard_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .clr (clr),
    .hz  (hif)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- behavioural model ----------------
  int          m_spent;      // stalled cycles already spent on the open access (0 = none open)
  bit          m_fault;      // this cycle is the fault-report cycle
  logic [31:0] m_sc, m_fc;   // model counters
  int          nx_spent;
  bit          nx_fault;
  bit          m_mstall, m_brflush;
  logic [1:0]  e_fwdA, e_fwdB;
  logic        e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fW, e_fault;
  logic [31:0] e_sc, e_fc;

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (hif.i_register_file_wr_en_M && hif.i_register_file_wr_addr_M != 0 &&
        hif.i_register_file_wr_addr_M == src) return 2'b10;
    if (hif.i_register_file_wr_en_W && hif.i_register_file_wr_addr_W != 0 &&
        hif.i_register_file_wr_addr_W == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_spent = 0;
    m_fault = 0;
    m_sc    = 0;
    m_fc    = 0;
  endtask

  task automatic model_eval();
    bit lu, br;
    e_fwdA = fwd_of(hif.i_rs1_E);
    e_fwdB = fwd_of(hif.i_rs2_E);
    nx_spent = m_spent;
    nx_fault = 0;
    m_mstall = 0;
    if (m_fault) begin
      nx_spent = 0;
    end else if (m_spent > 0) begin
      if (hif.i_data_memory_ready_M) nx_spent = 0;
      else begin
        m_mstall = 1;
        nx_spent = m_spent + 1;
        if (nx_spent == TO) begin nx_fault = 1; nx_spent = 0; end
      end
    end else if (hif.i_data_memory_req_M && !hif.i_data_memory_ready_M) begin
      m_mstall = 1;
      nx_spent = 1;
    end
    lu = hif.i_sel_result_E && hif.i_register_file_wr_en_E && hif.i_register_file_wr_addr_E != 0 &&
         (hif.i_register_file_wr_addr_E == hif.i_rs1_D || hif.i_register_file_wr_addr_E == hif.i_rs2_D);
    br = hif.i_branch_taken_E;
    e_sE = m_mstall; e_sM = m_mstall; e_fW = m_mstall;
    e_sF = m_mstall || (!br && lu);
    e_sD = e_sF;
    e_fD = !m_mstall && br;
    e_fE = !m_mstall && (br || lu);
    m_brflush = !m_mstall && br;
    e_fault = m_fault;
`ifdef HAZARD_PERF_CNT_EN
    e_sc = m_sc; e_fc = m_fc;
`else
    e_sc = 0; e_fc = 0;
`endif
  endtask

  task automatic model_commit();
    if (e_sF && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (m_brflush && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    m_spent = nx_spent;
    m_fault = nx_fault;
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic idle_inputs();
    hif.i_rs1_D = 0; hif.i_rs2_D = 0; hif.i_rs1_E = 0; hif.i_rs2_E = 0;
    hif.i_register_file_wr_addr_E = 0; hif.i_register_file_wr_en_E = 0; hif.i_sel_result_E = 0;
    hif.i_register_file_wr_addr_M = 0; hif.i_register_file_wr_en_M = 0;
    hif.i_register_file_wr_addr_W = 0; hif.i_register_file_wr_en_W = 0;
    hif.i_branch_taken_E = 0; hif.i_data_memory_req_M = 0; hif.i_data_memory_ready_M = 0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    clr = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clr = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] v;
    idle_inputs();
    clr = 1;
    model_reset();
    #1;
    v = {hif.o_fwdA_E, hif.o_fwdB_E, hif.o_stall_F, hif.o_stall_D, hif.o_stall_E, hif.o_stall_M,
         hif.o_flush_D, hif.o_flush_E, hif.o_flush_W, hif.o_mem_fault, 1'b0};
    n_total++;
    if (v !== 13'd0) $display("FAIL reset_outputs: got %b want 0", v); else n_pass++;
    n_total++;
    if ({hif.o_stall_cycles, hif.o_flush_count} !== 64'd0)
      $display("FAIL reset_counters: got %h/%h want 0/0", hif.o_stall_cycles, hif.o_flush_count);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    clr = 0;
    settle();
    n_total++;
    if (hif.o_stall_F !== 1'b0 || hif.o_mem_fault !== 1'b0)
      $display("FAIL post_reset_idle: stall_F=%b fault=%b want 0/0", hif.o_stall_F, hif.o_mem_fault);
    else n_pass++;
  endtask

  task automatic test_forwarding();
    apply_reset();
    hif.i_register_file_wr_addr_M = 5; hif.i_register_file_wr_en_M = 1;
    hif.i_register_file_wr_addr_W = 5; hif.i_register_file_wr_en_W = 1;
    hif.i_rs1_E = 5; hif.i_rs2_E = 0;
    settle();
    n_total++;
    if (hif.o_fwdA_E !== 2'b10) $display("FAIL fwd_m_priority: got %b want 10", hif.o_fwdA_E); else n_pass++;
    n_total++;
    if (hif.o_fwdB_E !== 2'b00) $display("FAIL fwd_x0_none: got %b want 00", hif.o_fwdB_E); else n_pass++;
    advance();
    hif.i_register_file_wr_en_M = 0;
    settle();
    n_total++;
    if (hif.o_fwdA_E !== 2'b01) $display("FAIL fwd_from_w: got %b want 01", hif.o_fwdA_E); else n_pass++;
    advance();
    hif.i_register_file_wr_addr_W = 0; hif.i_rs2_E = 0;
    settle();
    n_total++;
    if (hif.o_fwdA_E !== 2'b00) $display("FAIL fwd_w_x0: got %b want 00", hif.o_fwdA_E); else n_pass++;
    advance();
  endtask

  task automatic test_load_use();
    logic [31:0] want;
    apply_reset();
    hif.i_sel_result_E = 1; hif.i_register_file_wr_addr_E = 7; hif.i_register_file_wr_en_E = 1;
    hif.i_rs2_D = 7;
    settle();
    n_total++;
    if ({hif.o_stall_F, hif.o_stall_D, hif.o_flush_E, hif.o_stall_E, hif.o_flush_D} !== 5'b11100)
      $display("FAIL load_use_bubble: got %b want 11100",
               {hif.o_stall_F, hif.o_stall_D, hif.o_flush_E, hif.o_stall_E, hif.o_flush_D});
    else n_pass++;
    advance();
    hif.i_register_file_wr_addr_E = 0; hif.i_rs2_D = 0;
    settle();
    n_total++;
    if ({hif.o_stall_F, hif.o_stall_D, hif.o_flush_E} !== 3'b000)
      $display("FAIL load_use_x0: got %b want 000", {hif.o_stall_F, hif.o_stall_D, hif.o_flush_E});
    else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
    want = 32'd1;
`else
    want = 32'd0;
`endif
    n_total++;
    if (hif.o_stall_cycles !== want) $display("FAIL load_use_stall_cnt: got %0d want %0d", hif.o_stall_cycles, want);
    else n_pass++;
    advance();
  endtask

  task automatic test_branch();
    logic [31:0] want;
    apply_reset();
    hif.i_sel_result_E = 1; hif.i_register_file_wr_addr_E = 9; hif.i_register_file_wr_en_E = 1;
    hif.i_rs1_D = 9; hif.i_branch_taken_E = 1;
    settle();
    n_total++;
    if ({hif.o_flush_D, hif.o_flush_E, hif.o_stall_F, hif.o_stall_D} !== 4'b1100)
      $display("FAIL branch_over_load_use: got %b want 1100",
               {hif.o_flush_D, hif.o_flush_E, hif.o_stall_F, hif.o_stall_D});
    else n_pass++;
    advance();
    idle_inputs();
    settle();
`ifdef HAZARD_PERF_CNT_EN
    want = 32'd1;
`else
    want = 32'd0;
`endif
    n_total++;
    if (hif.o_flush_count !== want) $display("FAIL branch_flush_cnt: got %0d want %0d", hif.o_flush_count, want);
    else n_pass++;
    advance();
  endtask

  task automatic test_mem_stall();
    logic [31:0] want;
    apply_reset();
    hif.i_data_memory_req_M = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_total++;
      if ({hif.o_stall_F, hif.o_stall_D, hif.o_stall_E, hif.o_stall_M, hif.o_flush_W} !== 5'b11111)
        $display("FAIL mem_stall_c%0d: got %b want 11111", c,
                 {hif.o_stall_F, hif.o_stall_D, hif.o_stall_E, hif.o_stall_M, hif.o_flush_W});
      else n_pass++;
      advance();
    end
    hif.i_data_memory_ready_M = 1;
    settle();
    n_total++;
    if ({hif.o_stall_F, hif.o_stall_M, hif.o_flush_W, hif.o_mem_fault} !== 4'b0000)
      $display("FAIL mem_release: got %b want 0000",
               {hif.o_stall_F, hif.o_stall_M, hif.o_flush_W, hif.o_mem_fault});
    else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
    want = 32'd2;
`else
    want = 32'd0;
`endif
    n_total++;
    if (hif.o_stall_cycles !== want) $display("FAIL mem_stall_cnt: got %0d want %0d", hif.o_stall_cycles, want);
    else n_pass++;
    advance();
    idle_inputs();
  endtask

  task automatic test_mem_timeout();
    apply_reset();
    hif.i_data_memory_req_M = 1;
    hif.i_data_memory_ready_M = 0;
    for (int c = 1; c <= TO; c++) begin
      settle();
      n_total++;
      if (hif.o_stall_M !== 1'b1 || hif.o_mem_fault !== 1'b0)
        $display("FAIL timeout_stall_c%0d: stall_M=%b fault=%b want 1/0", c, hif.o_stall_M, hif.o_mem_fault);
      else n_pass++;
      advance();
    end
    settle();
    n_total++;
    if (hif.o_mem_fault !== 1'b1 || hif.o_stall_F !== 1'b0)
      $display("FAIL timeout_fault: fault=%b stall_F=%b want 1/0", hif.o_mem_fault, hif.o_stall_F);
    else n_pass++;
    advance();
    settle();
    n_total++;
    if (hif.o_stall_F !== 1'b1 || hif.o_mem_fault !== 1'b0)
      $display("FAIL timeout_restart: stall_F=%b fault=%b want 1/0", hif.o_stall_F, hif.o_mem_fault);
    else n_pass++;
    advance();
    hif.i_data_memory_ready_M = 1;
    settle();
    advance();
    idle_inputs();
  endtask

  task automatic test_clr_mid_wait();
    apply_reset();
    hif.i_data_memory_req_M = 1;
    settle();
    advance();
    hif.i_data_memory_req_M = 0;
    settle();
    n_total++;
    if (hif.o_stall_F !== 1'b1) $display("FAIL wait_holds: stall_F=%b want 1", hif.o_stall_F); else n_pass++;
    #2;
    clr = 1;
    model_reset();
    #1;
    n_total++;
    if ({hif.o_stall_F, hif.o_stall_M, hif.o_flush_W} !== 3'b000)
      $display("FAIL clr_async_drop: got %b want 000", {hif.o_stall_F, hif.o_stall_M, hif.o_flush_W});
    else n_pass++;
    n_total++;
    if ({hif.o_stall_cycles, hif.o_flush_count} !== 64'd0)
      $display("FAIL clr_counters: got %h/%h want 0/0", hif.o_stall_cycles, hif.o_flush_count);
    else n_pass++;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic test_branch_in_stall();
    apply_reset();
    hif.i_data_memory_req_M = 1; hif.i_branch_taken_E = 1;
    settle();
    n_total++;
    if ({hif.o_flush_D, hif.o_flush_E, hif.o_flush_W} !== 3'b001)
      $display("FAIL branch_in_stall: got %b want 001", {hif.o_flush_D, hif.o_flush_E, hif.o_flush_W});
    else n_pass++;
    advance();
    hif.i_data_memory_ready_M = 1;
    settle();
    n_total++;
    if ({hif.o_flush_D, hif.o_flush_E, hif.o_flush_W, hif.o_stall_F} !== 4'b1100)
      $display("FAIL branch_on_release: got %b want 1100",
               {hif.o_flush_D, hif.o_flush_E, hif.o_flush_W, hif.o_stall_F});
    else n_pass++;
    advance();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [12:0] got, want;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      hif.i_rs1_D = 5'($urandom_range(0, 3));
      hif.i_rs2_D = 5'($urandom_range(0, 3));
      hif.i_rs1_E = 5'($urandom_range(0, 3));
      hif.i_rs2_E = 5'($urandom_range(0, 3));
      hif.i_register_file_wr_addr_E = 5'($urandom_range(0, 3));
      hif.i_register_file_wr_en_E   = 1'($urandom_range(0, 1));
      hif.i_sel_result_E            = 1'($urandom_range(0, 1));
      hif.i_register_file_wr_addr_M = 5'($urandom_range(0, 3));
      hif.i_register_file_wr_en_M   = 1'($urandom_range(0, 1));
      hif.i_register_file_wr_addr_W = 5'($urandom_range(0, 3));
      hif.i_register_file_wr_en_W   = 1'($urandom_range(0, 1));
      hif.i_branch_taken_E          = ($urandom_range(0, 5) == 0);
      hif.i_data_memory_req_M       = ($urandom_range(0, 2) == 0);
      hif.i_data_memory_ready_M     = ($urandom_range(0, 3) == 0);
      settle();
      got  = {hif.o_fwdA_E, hif.o_fwdB_E, hif.o_stall_F, hif.o_stall_D, hif.o_stall_E, hif.o_stall_M,
              hif.o_flush_D, hif.o_flush_E, hif.o_flush_W, hif.o_mem_fault, 1'b0};
      want = {e_fwdA, e_fwdB, e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fW, e_fault, 1'b0};
      n_total++;
      if (got !== want) $display("FAIL rand_outputs c%0d: got %b want %b", c, got, want); else n_pass++;
      n_total++;
      if (hif.o_stall_cycles !== e_sc || hif.o_flush_count !== e_fc)
        $display("FAIL rand_counters c%0d: got %0d/%0d want %0d/%0d", c,
                 hif.o_stall_cycles, hif.o_flush_count, e_sc, e_fc);
      else n_pass++;
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_mem_timeout();
    test_clr_mid_wait();
    test_branch_in_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
